// File: rtl/cpu_pkg.sv
// Shared encodings for the CSC142 16-bit pipelined CPU: opcodes, function codes
// and the datapath control field values produced by the ID-stage decoder.
package cpu_pkg;

  localparam logic [3:0] OP_ATYPE = 4'b0000;
  localparam logic [3:0] OP_ANDI  = 4'b0001;
  localparam logic [3:0] OP_ORI   = 4'b0010;
  localparam logic [3:0] OP_BLT   = 4'b0100;
  localparam logic [3:0] OP_BGT   = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b0110;
  localparam logic [3:0] OP_JMP   = 4'b0111;
  localparam logic [3:0] OP_LBU   = 4'b1010;
  localparam logic [3:0] OP_SB    = 4'b1011;
  localparam logic [3:0] OP_LW    = 4'b1100;
  localparam logic [3:0] OP_SW    = 4'b1101;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0001;
  localparam logic [3:0] FN_MUL = 4'b0100;
  localparam logic [3:0] FN_DIV = 4'b0101;

  typedef enum logic [1:0] {ALU_ADD, ALU_FUNC, ALU_AND, ALU_OR} alu_op_e;
  // Shared by the Comparison request and the ComparatorInput result.
  typedef enum logic [1:0] {CMP_NONE, CMP_LT, CMP_GT, CMP_EQ} cmp_e;
  typedef enum logic [1:0] {RW_NONE, RW_RD, RW_RD_R0, RW_RSVD} reg_write_e;
  typedef enum logic [1:0] {EXT_NONE, EXT_SE4, EXT_ZE8, EXT_SE8} sign_ext_e;

  typedef struct packed {
    logic       alu_src1;
    logic       alu_src2;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       upper_zero;
    logic       jump;
    logic       str_byte;
    logic       exception;
    alu_op_e    alu_op;
    cmp_e       cmp;
    reg_write_e reg_write;
    sign_ext_e  sign_ext;
  } ctl_t;

endpackage

// File: rtl/branch_resolve.sv
// Conditional branch resolution: taken when the requested comparison matches the
// comparator result. Purely combinational, no backpressure.
module branch_resolve
  import cpu_pkg::*;
(
  input  cmp_e cmp_i,
  input  cmp_e cmp_result_i,
  output logic taken_o
);

  // A "none" request never matches, so non-branch opcodes cannot take.
  assign taken_o = (cmp_i != CMP_NONE) && (cmp_i == cmp_result_i);

endmodule

// File: rtl/main_control_unit.sv
// ID-stage decode/control for the CSC142 CPU: combinational outputs, single
// `halted` state bit that silences every output after HALT or an illegal instruction.
module main_control_unit
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] OPCode,
  input  logic [3:0] functionCode,
  input  logic [1:0] ComparatorInput,
  output logic       ALUSrc1,
  output logic       ALUSrc2,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       UpperByteToZero,
  output logic       TargetAddress,
  output logic       IFIDFlush,
  output logic       str_Byte,
  output logic       branch,
  output logic       Exception,
  output logic [1:0] ALUOp,
  output logic [1:0] Comparison,
  output logic [1:0] RegWrite,
  output logic [1:0] SignExtend
);

  ctl_t dec;
  logic taken;
  logic quiet;
  logic halted_q, halted_d;

  always_comb begin
    dec = '0;
    unique case (OPCode)
      OP_ATYPE: begin
        dec.alu_op = ALU_FUNC;
        if (functionCode == FN_ADD || functionCode == FN_SUB) begin
          dec.reg_write = RW_RD;
        end else if (functionCode == FN_MUL || functionCode == FN_DIV) begin
          dec.reg_write = RW_RD_R0;
        end else begin
          dec = '0;
          dec.exception = 1'b1;
        end
      end
      OP_ANDI, OP_ORI: begin
        dec.alu_src2  = 1'b1;
        dec.sign_ext  = EXT_ZE8;
        dec.alu_op    = (OPCode == OP_ANDI) ? ALU_AND : ALU_OR;
        dec.reg_write = RW_RD;
      end
      OP_BLT: begin dec.sign_ext = EXT_SE8; dec.cmp = CMP_LT; end
      OP_BGT: begin dec.sign_ext = EXT_SE8; dec.cmp = CMP_GT; end
      OP_BEQ: begin dec.sign_ext = EXT_SE8; dec.cmp = CMP_EQ; end
      OP_JMP: dec.jump = 1'b1;
      OP_LBU, OP_LW: begin
        dec.alu_src1   = 1'b1;
        dec.alu_src2   = 1'b1;
        dec.sign_ext   = EXT_SE4;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.upper_zero = (OPCode == OP_LBU);
        dec.reg_write  = RW_RD;
      end
      OP_SB, OP_SW: begin
        dec.alu_src1  = 1'b1;
        dec.alu_src2  = 1'b1;
        dec.sign_ext  = EXT_SE4;
        dec.mem_write = 1'b1;
        dec.str_byte  = (OPCode == OP_SB);
      end
      OP_HALT: dec = '0;
      default: dec.exception = 1'b1;
    endcase
  end

  branch_resolve u_branch_resolve (
    .cmp_i        (dec.cmp),
    .cmp_result_i (cmp_e'(ComparatorInput)),
    .taken_o      (taken)
  );

  assign halted_d = halted_q | (OPCode == OP_HALT) | dec.exception;

  always_ff @(posedge clk) begin
    if (rst) halted_q <= 1'b0;
    else     halted_q <= halted_d;
  end

  // Reset and the halted state both force a NOP on every output.
  assign quiet = rst | halted_q;

  assign ALUSrc1         = ~quiet & dec.alu_src1;
  assign ALUSrc2         = ~quiet & dec.alu_src2;
  assign MemRead         = ~quiet & dec.mem_read;
  assign MemWrite        = ~quiet & dec.mem_write;
  assign MemtoReg        = ~quiet & dec.mem_to_reg;
  assign UpperByteToZero = ~quiet & dec.upper_zero;
  assign TargetAddress   = ~quiet & dec.jump;
  assign IFIDFlush       = ~quiet & (taken | dec.jump);
  assign str_Byte        = ~quiet & dec.str_byte;
  assign branch          = ~quiet & taken;
  assign Exception       = ~quiet & dec.exception;
  assign ALUOp           = quiet ? 2'b00 : dec.alu_op;
  assign Comparison      = quiet ? 2'b00 : dec.cmp;
  assign RegWrite        = quiet ? 2'b00 : dec.reg_write;
  assign SignExtend      = quiet ? 2'b00 : dec.sign_ext;

endmodule

// File: tb/tb_main_control_unit.sv
// Bench for main_control_unit: per-cycle comparison against a behavioural decode
// model, plus directed vectors with hand-written expected control words.
module tb_main_control_unit;

  typedef struct packed {
    logic       a1, a2, mr, mw, m2r, ub, ta, fl, sb, br, ex;
    logic [1:0] aop, cmp, rw, se;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] op = 4'd0;
  logic [3:0] fn = 4'd0;
  logic [1:0] cin = 2'd0;

  logic ALUSrc1, ALUSrc2, MemRead, MemWrite, MemtoReg, UpperByteToZero;
  logic TargetAddress, IFIDFlush, str_Byte, branch, Exception;
  logic [1:0] ALUOp, Comparison, RegWrite, SignExtend;

  int   errors = 0;
  int   checks = 0;
  bit   done = 1'b0;
  logic m_halt = 1'b0;
  vec_t dut;

  main_control_unit u_dut (
    .clk(clk), .rst(rst), .OPCode(op), .functionCode(fn), .ComparatorInput(cin),
    .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .UpperByteToZero(UpperByteToZero), .TargetAddress(TargetAddress),
    .IFIDFlush(IFIDFlush), .str_Byte(str_Byte), .branch(branch), .Exception(Exception),
    .ALUOp(ALUOp), .Comparison(Comparison), .RegWrite(RegWrite), .SignExtend(SignExtend)
  );

  assign dut = {ALUSrc1, ALUSrc2, MemRead, MemWrite, MemtoReg, UpperByteToZero,
                TargetAddress, IFIDFlush, str_Byte, branch, Exception,
                ALUOp, Comparison, RegWrite, SignExtend};

  always #5 clk = ~clk;

  // Instruction-level meaning of each opcode; branch kinds 4/5/6 request compare 1/2/3.
  function automatic vec_t model(input logic [3:0] o, input logic [3:0] f,
                                 input logic [1:0] c, input logic h, input logic r);
    vec_t v;
    v = '0;
    if (r || h) return v;
    if (o == 4'd0) begin
      if (f == 4'd0 || f == 4'd1)      begin v.aop = 2'd1; v.rw = 2'd1; end
      else if (f == 4'd4 || f == 4'd5) begin v.aop = 2'd1; v.rw = 2'd2; end
      else v.ex = 1'b1;
    end else if (o == 4'd1 || o == 4'd2) begin
      v.a2 = 1'b1; v.se = 2'd2; v.rw = 2'd1; v.aop = 2'(o) + 2'd1;
    end else if (o >= 4'd4 && o <= 4'd6) begin
      v.se = 2'd3; v.cmp = 2'(o - 4'd3); v.br = (c == v.cmp); v.fl = v.br;
    end else if (o == 4'd7) begin
      v.ta = 1'b1; v.fl = 1'b1;
    end else if (o >= 4'd10 && o <= 4'd13) begin
      v.a1 = 1'b1; v.a2 = 1'b1; v.se = 2'd1;
      if (o[0] == 1'b0) begin v.mr = 1'b1; v.m2r = 1'b1; v.rw = 2'd1; v.ub = (o == 4'd10); end
      else begin v.mw = 1'b1; v.sb = (o == 4'd11); end
    end else if (o != 4'd15) begin
      v.ex = 1'b1;
    end
    return v;
  endfunction

  always @(posedge clk) begin
    vec_t raw;
    raw = model(op, fn, cin, 1'b0, 1'b0);
    m_halt <= rst ? 1'b0 : (m_halt | (op == 4'd15) | raw.ex);
  end

  always @(negedge clk) begin
    vec_t e;
    if (!done) begin
      e = model(op, fn, cin, m_halt, rst);
      checks++;
      if (dut !== e) begin
        errors++;
        $display("FAIL cycle op=%h fn=%h cin=%0d rst=%0b: got %h want %h",
                 op, fn, cin, rst, dut, e);
      end
    end
  end

  task automatic step(input logic [3:0] o, input logic [3:0] f,
                      input logic [1:0] c, input logic r);
    @(posedge clk);
    #1;
    op = o; fn = f; cin = c; rst = r;
  endtask

  // Hand-written expectation: checks the DUT and the model against the same literal.
  task automatic lit(input string name, input vec_t e);
    vec_t m;
    #2;
    m = model(op, fn, cin, m_halt, rst);
    checks++;
    if (dut !== e) begin
      errors++;
      $display("FAIL %s: dut %h want %h", name, dut, e);
    end
    checks++;
    if (m !== e) begin
      errors++;
      $display("FAIL %s(model): model %h want %h", name, m, e);
    end
  endtask

  vec_t z, e;
  logic [3:0] bad_ops [4];

  initial begin
    z = '0;
    bad_ops[0] = 4'd3; bad_ops[1] = 4'd8; bad_ops[2] = 4'd9; bad_ops[3] = 4'd14;

    step(4'd0, 4'd0, 2'd0, 1'b1); lit("reset_add", z);
    step(4'd15, 4'd2, 2'd3, 1'b1); lit("reset_halt", z);

    step(4'd0, 4'd0, 2'd0, 1'b0);
    e = z; e.aop = 2'd1; e.rw = 2'd1; lit("add", e);
    step(4'd0, 4'd1, 2'd3, 1'b0); lit("sub", e);
    step(4'd0, 4'd5, 2'd0, 1'b0);
    e = z; e.aop = 2'd1; e.rw = 2'd2; lit("div", e);
    step(4'd0, 4'd4, 2'd0, 1'b0); lit("mul", e);

    for (int b = 0; b < 3; b++) begin
      for (int c = 0; c < 4; c++) begin
        step(4'(4 + b), 4'd0, 2'(c), 1'b0);
        e = z; e.se = 2'd3; e.cmp = 2'(b + 1);
        if (c == b + 1) begin e.br = 1'b1; e.fl = 1'b1; end
        lit("branch", e);
      end
    end

    step(4'd10, 4'd0, 2'd0, 1'b0);
    e = z; e.a1 = 1; e.a2 = 1; e.se = 2'd1; e.mr = 1; e.m2r = 1; e.ub = 1; e.rw = 2'd1;
    lit("lbu", e);
    step(4'd12, 4'd0, 2'd0, 1'b0);
    e.ub = 0; lit("lw", e);
    step(4'd11, 4'd0, 2'd0, 1'b0);
    e = z; e.a1 = 1; e.a2 = 1; e.se = 2'd1; e.mw = 1; e.sb = 1; lit("sb", e);
    step(4'd13, 4'd0, 2'd0, 1'b0);
    e.sb = 0; lit("sw", e);
    step(4'd1, 4'd0, 2'd0, 1'b0);
    e = z; e.a2 = 1; e.se = 2'd2; e.aop = 2'd2; e.rw = 2'd1; lit("andi", e);
    step(4'd2, 4'd0, 2'd0, 1'b0);
    e.aop = 2'd3; lit("ori", e);
    step(4'd7, 4'd0, 2'd3, 1'b0);
    e = z; e.ta = 1; e.fl = 1; lit("jmp", e);

    step(4'd0, 4'd2, 2'd0, 1'b0);
    e = z; e.ex = 1; lit("bad_func", e);
    step(4'd0, 4'd0, 2'd0, 1'b0); lit("halted_after_exc", z);
    step(4'd3, 4'd0, 2'd0, 1'b0); lit("halted_hides_exc", z);
    step(4'd12, 4'd0, 2'd0, 1'b1); lit("reset_lw", z);

    step(4'd15, 4'd0, 2'd0, 1'b0); lit("halt", z);
    step(4'd12, 4'd0, 2'd0, 1'b0); lit("halted_lw", z);
    step(4'd12, 4'd0, 2'd0, 1'b1);
    step(4'd12, 4'd0, 2'd0, 1'b0);
    e = z; e.a1 = 1; e.a2 = 1; e.se = 2'd1; e.mr = 1; e.m2r = 1; e.rw = 2'd1;
    lit("lw_after_reset", e);

    step(4'd15, 4'd0, 2'd0, 1'b1);
    step(4'd12, 4'd0, 2'd0, 1'b0); lit("reset_beats_halt", e);
    step(4'd9, 4'd0, 2'd0, 1'b1);
    step(4'd12, 4'd0, 2'd0, 1'b0); lit("reset_beats_exc", e);

    foreach (bad_ops[i]) begin
      step(bad_ops[i], 4'd0, 2'd3, 1'b0);
      e = z; e.ex = 1; lit("bad_op", e);
      step(4'd7, 4'd0, 2'd0, 1'b0); lit("bad_op_halts", z);
      step(4'd0, 4'd0, 2'd0, 1'b1);
    end

    step(4'd6, 4'd0, 2'd3, 1'b0);
    @(posedge clk);
    #1;
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/main_control_unit.md
Name: main_control_unit

Overview:
- Main decode and control unit for the 16-bit CSC142 pipelined CPU datapath; sits in the ID stage.
- Decodes the 4-bit opcode and 4-bit function code into datapath control signals.
- Resolves conditional branches from the comparator result and flushes IF/ID on any taken control transfer.
- Flags illegal instructions. Holds one state bit, `halted`, that freezes the machine after HALT or an exception.

Parameters:
- None. Encodings are constants in the shared package.

Ports:
- clk  in  1  system clock; `halted` updates on the rising edge
- rst  in  1  synchronous, active-high reset
- OPCode  in  4  instruction bits [15:12]
- functionCode  in  4  instruction bits [3:0]; meaningful only for opcode 0000
- ComparatorInput  in  2  ID-stage comparator result: 00 = none, 01 = op1<op2, 10 = op1>op2, 11 = equal
- ALUSrc1  out  1  1 = base-register field as ALU operand 1 (loads/stores)
- ALUSrc2  out  1  1 = extended immediate as ALU operand 2
- MemRead  out  1  data-memory read
- MemWrite  out  1  data-memory write
- MemtoReg  out  1  1 = write-back data comes from memory
- UpperByteToZero  out  1  clear loaded bits [15:8] (byte load)
- TargetAddress  out  1  0 = PC-relative branch target, 1 = jump target
- IFIDFlush  out  1  flush IF/ID register
- str_Byte  out  1  byte-width store
- branch  out  1  conditional branch taken
- Exception  out  1  illegal opcode or function code
- ALUOp  out  2  00 = add, 01 = use functionCode, 10 = AND, 11 = OR
- Comparison  out  2  comparison requested: 00 = none, 01 = lt, 10 = gt, 11 = eq
- RegWrite  out  2  00 = none, 01 = write Rd, 10 = write Rd plus R0 (mul/div high word or remainder)
- SignExtend  out  2  00 = none, 01 = sign-extend 4-bit offset, 10 = zero-extend 8-bit immediate, 11 = sign-extend 8-bit branch offset

Behaviour:
- All outputs are combinational from the inputs and `halted`.
- Default: every output is 0 (NOP). Each opcode asserts only the signals listed below.
- 0000, A-type: ALUOp=01.
  - Func 0000 ADD and 0001 SUB: RegWrite=01.
  - Func 0100 MUL and 0101 DIV: RegWrite=10.
  - Any other func: Exception=1, all other outputs 0.
- 0001 ANDI: ALUSrc2=1, SignExtend=10, ALUOp=10, RegWrite=01.
- 0010 ORI: same as ANDI but ALUOp=11.
- 0100 BLT, 0101 BGT, 0110 BEQ:
  - SignExtend=11, TargetAddress=0.
  - Comparison=01 / 10 / 11 respectively.
  - branch = (ComparatorInput == Comparison); IFIDFlush = branch.
  - ComparatorInput=00 never takes.
- 0111 JMP: TargetAddress=1, IFIDFlush=1, branch=0.
- 1010 LBU:
  - ALUSrc1=1, ALUSrc2=1, SignExtend=01, ALUOp=00.
  - MemRead=1, MemtoReg=1, UpperByteToZero=1, RegWrite=01.
- 1011 SB: ALUSrc1=1, ALUSrc2=1, SignExtend=01, ALUOp=00, MemWrite=1, str_Byte=1.
- 1100 LW: same as LBU but UpperByteToZero=0.
- 1101 SW: same as SB but str_Byte=0.
- 1111 HALT: all outputs 0; sets `halted` on the next clk edge.
- 0011, 1000, 1001, 1110: Exception=1, all others 0; sets `halted` on the next edge.
- `halted` register:
  - rst=1 at a clk edge clears it.
  - Set when not in reset and (opcode==1111 or Exception==1).
  - Once set, all outputs are forced to 0, including Exception, until reset.
- While rst=1, all outputs are forced to 0 regardless of the inputs. Reset takes priority over a simultaneous HALT or exception.
- No internal latency beyond combinational delay. The only cycle effect is `halted`.

Decomposition:
- Shared package `cpu_pkg`:
  - opcode constants (OP_ATYPE, OP_ANDI, OP_ORI, OP_BLT, OP_BGT, OP_BEQ, OP_JMP, OP_LBU, OP_SB, OP_LW, OP_SW, OP_HALT)
  - function-code constants
  - ALUOp, SignExtend, RegWrite and Comparison encodings
  - ComparatorInput encoding
- Sub-module `branch_resolve`: combinational; takes Comparison and ComparatorInput, produces branch. IFIDFlush is derived from branch in the parent.
- The decode case statement and the `halted` flop stay in the top module.

Test Plan:
- rst=1 then release; OPCode=0000, func=0000 → RegWrite=01, ALUOp=01, all others 0. Same with func=0101 → RegWrite=10. Func=0010 → Exception=1; next edge `halted`=1 and all outputs 0.
- OPCode 0100, 0101, 0110 each swept with ComparatorInput 00/01/10/11:
  - branch=IFIDFlush=1 only for the pairs 0100/01, 0101/10, 0110/11.
  - Comparison=01/10/11 respectively; SignExtend=11 throughout.
- OPCode=1010 → MemRead=MemtoReg=UpperByteToZero=1, ALUSrc1=ALUSrc2=1, SignExtend=01, RegWrite=01. OPCode=1100 → same with UpperByteToZero=0. OPCode=1011 → MemWrite=str_Byte=1. OPCode=1101 → MemWrite=1, str_Byte=0.
- OPCode=0001 → ALUOp=10, SignExtend=10. OPCode=0010 → ALUOp=11. OPCode=0111 → TargetAddress=1, IFIDFlush=1, branch=0.
- OPCode=1111 for one cycle, then OPCode=1100 → all outputs 0. Assert rst one cycle → 1100 decodes normally again.
- rst=1 in the same cycle as OPCode=1111 → `halted` stays 0 after that edge.
